// File: rtl/instr_pkg.sv
// Shared constants and the loader state encoding for the instruction-memory writer.
package instr_pkg;

    localparam int          A_length   = 12;
    localparam int          D_length   = 8;
    localparam logic [31:0] IMEM_BASE  = 32'hBFC00000;
    localparam int          IMEM_BYTES = 4096;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        WRITE  = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } loader_state_e;

endpackage

// File: rtl/word_byte_serializer.sv
// Holds one captured 32-bit word and presents it one little-endian byte at a time.
module word_byte_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        advance_i,
    input  logic        clear_i,
    output logic [7:0]  byte_o,
    output logic [1:0]  idx_o,
    output logic        last_byte_o
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;
    logic [1:0]  idx_d;
    logic [7:0]  byte_q;

    assign idx_d = idx_q + 2'd1;

    // byte_q is registered so the memory sees a clean, glitch-free data bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx_q  <= '0;
            byte_q <= '0;
        end else if (load_i) begin
            word_q <= word_i;
            idx_q  <= 2'd0;
            byte_q <= word_i[7:0];
        end else if (advance_i) begin
            idx_q  <= idx_d;
            byte_q <= word_q[{idx_d, 3'b000} +: 8];
        end else if (clear_i) begin
            idx_q  <= 2'd0;
            byte_q <= '0;
        end
    end

    assign byte_o      = byte_q;
    assign idx_o       = idx_q;
    assign last_byte_o = (idx_q == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Accepts 32-bit instruction words over valid/ready and writes them byte-wise,
// little-endian, into the 4096 x 8 instruction memory starting at a word-aligned offset.
module instr_mem_loader
    import instr_pkg::*;
#(
    parameter int A_length = instr_pkg::A_length,
    parameter int D_length = instr_pkg::D_length
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [A_length-1:0] base_addr,
    input  logic                word_valid,
    input  logic [31:0]         word_data,
    input  logic                word_last,
    output logic                word_ready,
    output logic                wr_en,
    output logic [A_length-1:0] wr_addr,
    output logic [D_length-1:0] wr_data,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int PW = A_length - 2;

    // Handshake: a word transfers on a rising clk edge where word_valid & word_ready;
    // the source holds word_data/word_last stable until then, and may drop valid freely.

    loader_state_e  state_q;
    logic [PW-1:0]  ptr_q;
    logic           full_q;
    logic           last_q;
    logic           wr_en_q;
    logic [A_length-1:0] wr_addr_q;
    logic           busy_q;
    logic           done_q;
    logic           err_q;

    logic           hs;
    logic           ser_load;
    logic           ser_advance;
    logic           ser_clear;
    logic [7:0]     ser_byte;
    logic [1:0]     ser_idx;
    logic [1:0]     wr_idx_d;
    logic           ser_last;
    logic           unused_base_bits;

    assign unused_base_bits = ^base_addr[1:0];

    assign hs          = (state_q == ACCEPT) && word_valid;
    assign ser_load    = hs && !full_q;
    assign ser_advance = (state_q == WRITE) && !ser_last;
    assign ser_clear   = (state_q == WRITE) && ser_last;
    assign wr_idx_d    = ser_idx + 2'd1;

    word_byte_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (ser_load),
        .word_i      (word_data),
        .advance_i   (ser_advance),
        .clear_i     (ser_clear),
        .byte_o      (ser_byte),
        .idx_o       (ser_idx),
        .last_byte_o (ser_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            full_q    <= 1'b0;
            last_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        ptr_q   <= base_addr[A_length-1:2];
                        full_q  <= 1'b0;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (hs) begin
                        if (full_q) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ERR;
                        end else begin
                            last_q    <= word_last;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= {ptr_q, 2'b00};
                            state_q   <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (ser_last) begin
                        wr_en_q   <= 1'b0;
                        wr_addr_q <= '0;
                        // The top slot saturates into the full flag instead of wrapping.
                        if (&ptr_q) full_q <= 1'b1;
                        else        ptr_q  <= ptr_q + PW'(1);
                        if (last_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            state_q <= ACCEPT;
                        end
                    end else begin
                        wr_addr_q <= {ptr_q, wr_idx_d};
                    end
                end
                default: begin
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign word_ready = (state_q == ACCEPT);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = D_length'(ser_byte);
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a driver pushes expected byte writes
// (cycle, address, data) into a queue and a negedge monitor pops and compares them.
module tb_instr_mem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // expected entry: {cycle[31:0], addr[11:0], data[7:0]}
    logic [51:0] exp_q[$];
    logic [7:0]  mem[4096];

    instr_mem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_last  (word_last),
        .word_ready (word_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            logic [51:0] e;
            mem[wr_addr] = wr_data;
            check("ready_low_in_write", {31'd0, word_ready}, 32'd0);
            check("busy_in_write", {31'd0, busy}, 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", {20'd0, wr_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("write_cycle", cyc, e[51:20]);
                check("write_addr", {20'd0, wr_addr}, {20'd0, e[19:8]});
                check("write_data", {24'd0, wr_data}, {24'd0, e[7:0]});
            end
        end
    end

    // driver tasks (each starts and ends just after a negedge)
    task automatic do_start(input logic [11:0] b);
        @(negedge clk);
        base_addr = b;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        check("start_done_clr", {31'd0, done}, 32'd0);
        check("start_err_clr", {31'd0, err}, 32'd0);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_ready", {31'd0, word_ready}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic [11:0] a,
                             input bit expect_write);
        int t;
        word_valid = 1'b1;
        word_data  = d;
        word_last  = last;
        t = 0;
        while (!word_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!word_ready) check("ready_timeout", 32'd0, 32'd1);
        if (expect_write) begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back({32'(cyc + 1 + k), a + 12'(k), d[8*k +: 8]});
        end
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(done || err) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!(done || err)) check("end_timeout", 32'd0, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        int t;
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_valid = 1'b0;
        word_data  = '0;
        word_last  = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        #12;
        check("rst_outputs", {24'd0, word_ready, wr_en, busy, done, err, 3'd0}, 32'd0);
        check("rst_addr_data", {12'd0, wr_addr, wr_data}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: single word, last=1
        do_start(12'h000);
        send_word(32'h00500093, 1'b1, 12'h000, 1'b1);
        wait_end();
        check("t1_bytes", {mem[3], mem[2], mem[1], mem[0]}, 32'h00500093);
        check("t1_done", {29'd0, done, busy, err}, 32'b100);

        // 2: unaligned base, three words
        do_start(12'h012);
        send_word(32'h11223344, 1'b0, 12'h010, 1'b1);
        send_word(32'h55667788, 1'b0, 12'h014, 1'b1);
        send_word(32'h99AABBCC, 1'b1, 12'h018, 1'b1);
        wait_end();
        check("t2_byte_010", {24'd0, mem[12'h010]}, 32'h44);
        check("t2_byte_01b", {24'd0, mem[12'h01B]}, 32'h99);
        check("t2_fetch_014", {mem[12'h017], mem[12'h016], mem[12'h015], mem[12'h014]}, 32'h55667788);
        check("t2_done", {29'd0, done, busy, err}, 32'b100);

        // 3: overflow past the top of memory
        do_start(12'hFF8);
        send_word(32'hA1A2A3A4, 1'b0, 12'hFF8, 1'b1);
        send_word(32'hB1B2B3B4, 1'b0, 12'hFFC, 1'b1);
        send_word(32'hC1C2C3C4, 1'b0, 12'h000, 1'b0);
        wait_end();
        check("t3_err", {29'd0, done, busy, err}, 32'b001);
        check("t3_ready_low", {31'd0, word_ready}, 32'd0);
        check("t3_top_word", {mem[12'hFFF], mem[12'hFFE], mem[12'hFFD], mem[12'hFFC]}, 32'hB1B2B3B4);

        // 4: backpressure with start pulsed during WRITE
        do_start(12'h040);
        send_word(32'h0A0B0C0D, 1'b0, 12'h040, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_start_ignored_busy", {31'd0, busy}, 32'd1);
        check("t4_start_ignored_wr", {31'd0, wr_en}, 32'd1);
        @(negedge clk);
        send_word(32'h1A1B1C1D, 1'b1, 12'h044, 1'b1);
        wait_end();
        check("t4_done", {29'd0, done, busy, err}, 32'b100);

        // 5: asynchronous reset during byte-2 write
        do_start(12'h300);
        send_word(32'hCAFEF00D, 1'b1, 12'h300, 1'b1);
        t = 0;
        while (!(wr_en && wr_addr == 12'h302) && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("t5_reach_byte2", {20'd0, wr_addr}, 32'h302);
        rst = 1'b1;
        #1;
        check("t5_async_outputs", {24'd0, word_ready, wr_en, busy, done, err, 3'd0}, 32'd0);
        check("t5_async_addr_data", {12'd0, wr_addr, wr_data}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        do_start(12'h100);
        send_word(32'h00112233, 1'b1, 12'h100, 1'b1);
        wait_end();
        check("t5_done", {29'd0, done, busy, err}, 32'b100);

        // 6: restart from DONE
        do_start(12'h200);
        send_word(32'hDEADBEEF, 1'b1, 12'h200, 1'b1);
        wait_end();
        check("t6_bytes", {mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]}, 32'hDEADBEEF);
        check("t6_done", {29'd0, done, busy, err}, 32'b100);

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
